way_select_ctrl: RTL and testbench

- Tag-lookup and replacement controller that sits directly upstream of the way-data multiplexor in the L2 cache simulator.
- For each request it compares the tag against every way of the indexed set.
- It produces the way index that drives the multiplexor's select input: the hit way, or the pseudo-LRU (PLRU) victim on a miss.
- It maintains per-set valid bits, tags and tree-PLRU state, with a valid/ready handshake on both request and response.

---
 rtl/way_select_ctrl_pkg.sv | 33 +++
 rtl/way_select_ctrl_if.sv | 40 ++++
 rtl/way_select_ctrl_plru.sv | 44 ++++
 rtl/way_select_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_way_select_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/way_select_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg: shared definitions for the L2 way-select controller slice.
//   - op_e      : request opcodes (encoding 3 is reserved and decodes as PROBE)
//   - state_e   : controller FSM states
//   - DEF_*     : default geometry of the simulated L2
//   - WAY_W     : width of a way index for the default associativity
//   - decode_op : maps the raw 2-bit request opcode onto op_e
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int DEF_SETS     = 4;
  localparam int DEF_WAYS     = 8;
  localparam int DEF_TAG_BITS = 8;
  localparam int WAY_W        = $clog2(DEF_WAYS);

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'd0,
    OP_PROBE      = 2'd1,
    OP_INVALIDATE = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // The reserved encoding behaves as a side-effect-free PROBE.
  function automatic op_e decode_op(input logic [1:0] raw);
    return (raw == 2'd3) ? OP_PROBE : op_e'(raw);
  endfunction

endpackage

// File: rtl/way_select_ctrl_if.sv
// ---------------------------------------------------------------------------
// way_select_if: request/response handshake bundle of the way-select
// controller.
//   master : requester side (drives req_*, resp_ready)
//   slave  : controller side (drives req_ready, resp_*)
// Request : req_valid/req_ready, req_op, req_set, req_tag
// Response: resp_valid/resp_ready, resp_hit, resp_way, resp_evict_valid,
//           resp_evict_tag
// ---------------------------------------------------------------------------
interface way_select_if #(
  parameter int sets     = cache_pkg::DEF_SETS,
  parameter int ways     = cache_pkg::DEF_WAYS,
  parameter int tag_bits = cache_pkg::DEF_TAG_BITS
);
  localparam int set_w = $clog2(sets);
  localparam int way_w = $clog2(ways);

  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [set_w-1:0]    req_set;
  logic [tag_bits-1:0] req_tag;

  logic                resp_valid;
  logic                resp_ready;
  logic                resp_hit;
  logic [way_w-1:0]    resp_way;
  logic                resp_evict_valid;
  logic [tag_bits-1:0] resp_evict_tag;

  modport master (
    output req_valid, req_op, req_set, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag
  );

  modport slave (
    input  req_valid, req_op, req_set, req_tag, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag
  );
endinterface

// File: rtl/way_select_ctrl_plru.sv
// ---------------------------------------------------------------------------
// plru_tree: combinational tree pseudo-LRU helper for one set.
//   nodes      in  ways-1 node bits, heap order (root = 0, children 2i+1/2i+2);
//                  a 0 points at the lower-index half, a 1 at the upper half
//   touch_way  in  way being made most-recently used
//   victim     out way reached by following the node pointers from the root
//   nodes_next out nodes with every node on touch_way's path pointing away
// ---------------------------------------------------------------------------
module plru_tree #(
  parameter int ways = 8
) (
  input  logic [ways-2:0]         nodes,
  input  logic [$clog2(ways)-1:0] touch_way,
  output logic [$clog2(ways)-1:0] victim,
  output logic [ways-2:0]         nodes_next
);
  localparam int way_w = $clog2(ways);

  // Way index bits are consumed MSB first: the root splits the ways in half.
  always_comb begin : walk_victim
    logic [way_w-1:0] idx;
    // NOTE: every variable of a combinational block gets a value before any
    // branch can skip it; otherwise synthesis infers a latch to hold it.
    idx    = '0;
    victim = '0;
    for (int lvl = 0; lvl < way_w; lvl++) begin
      victim[way_w-1-lvl] = nodes[idx];
      idx = way_w'(2 * idx + 1 + nodes[idx]);
    end
  end

  always_comb begin : walk_touch
    logic [way_w-1:0] idx;
    logic             dir;
    idx        = '0;
    dir        = 1'b0;
    nodes_next = nodes;
    for (int lvl = 0; lvl < way_w; lvl++) begin
      dir             = touch_way[way_w-1-lvl];
      nodes_next[idx] = ~dir;
      idx = way_w'(2 * idx + 1 + dir);
    end
  end
endmodule

// File: rtl/way_select_ctrl.sv
// ---------------------------------------------------------------------------
// way_select_ctrl: tag lookup and replacement controller feeding the select
// input of the L2 way-data multiplexor.
//   clk    in  clock, all state changes on the rising edge
//   reset  in  synchronous, active-high
//   bus    slave side of way_select_if (request and response handshakes)
// A request is captured in IDLE, matched against every way of its set in
// LOOKUP (where the valid/tag/PLRU arrays are also updated), and the result
// is held in RESP until the consumer takes it.
// ---------------------------------------------------------------------------
module way_select_ctrl
  import cache_pkg::*;
#(
  parameter int sets     = DEF_SETS,
  parameter int ways     = DEF_WAYS,
  parameter int tag_bits = DEF_TAG_BITS
) (
  input logic        clk,
  input logic        reset,
  way_select_if.slave bus
);
  localparam int set_w = $clog2(sets);
  localparam int way_w = $clog2(ways);

  // Control and captured request.
  state_e              state_q, state_d;
  op_e                 op_q;
  logic [set_w-1:0]    set_q;
  logic [tag_bits-1:0] tag_in_q;
  logic                accept;

  // Per-set arrays.
  logic [ways-1:0]     valid_q [sets];
  logic [tag_bits-1:0] tags_q  [sets][ways];
  logic [ways-2:0]     plru_q  [sets];

  // Registered response.
  logic                resp_hit_q, resp_evict_valid_q;
  logic [way_w-1:0]    resp_way_q;
  logic [tag_bits-1:0] resp_evict_tag_q;

  // Lookup datapath for the captured set.
  logic [ways-1:0]     set_valid, hit_vec;
  logic [ways-2:0]     set_plru, plru_touched;
  logic                any_hit, any_invalid;
  logic [way_w-1:0]    hit_way, free_way, plru_victim, victim, touch_way;

  // Next response and array update controls.
  logic                hit_d, evict_valid_d;
  logic [way_w-1:0]    way_d;
  logic [tag_bits-1:0] evict_tag_d;
  logic                do_fill, do_clear, do_touch;

  // Handshakes are suppressed while reset is held so an in-flight request
  // never produces a response.
  assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.resp_valid = (state_q == ST_RESP) && !reset;
  assign accept         = bus.req_valid && bus.req_ready;

  assign bus.resp_hit         = resp_hit_q;
  assign bus.resp_way         = resp_way_q;
  assign bus.resp_evict_valid = resp_evict_valid_q;
  assign bus.resp_evict_tag   = resp_evict_tag_q;

  assign set_valid = valid_q[set_q];
  assign set_plru  = plru_q[set_q];

  // Tag match and lowest-index invalid way; scanning downwards lets the
  // lowest matching index win.
  always_comb begin
    hit_vec     = '0;
    any_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    free_way    = '0;
    for (int w = 0; w < ways; w++) begin
      hit_vec[w] = set_valid[w] && (tags_q[set_q][w] == tag_in_q);
    end
    for (int w = ways - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        any_hit = 1'b1;
        hit_way = way_w'(w);
      end
      if (!set_valid[w]) begin
        any_invalid = 1'b1;
        free_way    = way_w'(w);
      end
    end
  end

  assign victim    = any_invalid ? free_way : plru_victim;
  assign touch_way = any_hit ? hit_way : victim;

  plru_tree #(.ways(ways)) u_plru (
    .nodes      (set_plru),
    .touch_way  (touch_way),
    .victim     (plru_victim),
    .nodes_next (plru_touched)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hit_d         = any_hit;
    way_d         = '0;
    evict_valid_d = 1'b0;
    evict_tag_d   = '0;
    do_fill       = 1'b0;
    do_clear      = 1'b0;
    do_touch      = 1'b0;
    case (op_q)
      OP_LOOKUP: begin
        do_touch = 1'b1;
        if (any_hit) begin
          way_d = hit_way;
        end else begin
          way_d         = victim;
          evict_valid_d = set_valid[victim];
          evict_tag_d   = set_valid[victim] ? tags_q[set_q][victim] : '0;
          do_fill       = 1'b1;
        end
      end
      OP_INVALIDATE: begin
        if (any_hit) begin
          way_d    = hit_way;
          do_clear = 1'b1;
        end
      end
      default: begin
        // PROBE reports what a LOOKUP would, without touching any state.
        way_d = any_hit ? hit_way : victim;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      op_q               <= OP_LOOKUP;
      set_q              <= '0;
      tag_in_q           <= '0;
      resp_hit_q         <= 1'b0;
      resp_way_q         <= '0;
      resp_evict_valid_q <= 1'b0;
      resp_evict_tag_q   <= '0;
      for (int s = 0; s < sets; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= decode_op(bus.req_op);
        set_q    <= bus.req_set;
        tag_in_q <= bus.req_tag;
      end
      // Arrays commit on the LOOKUP->RESP edge so the next request already
      // sees this one's effect.
      if (state_q == ST_LOOKUP) begin
        resp_hit_q         <= hit_d;
        resp_way_q         <= way_d;
        resp_evict_valid_q <= evict_valid_d;
        resp_evict_tag_q   <= evict_tag_d;
        if (do_fill)  valid_q[set_q][victim]  <= 1'b1;
        if (do_clear) valid_q[set_q][hit_way] <= 1'b0;
        if (do_touch) plru_q[set_q]           <= plru_touched;
      end
    end
  end

  // NOTE: tag storage has no reset; the cleared valid bits already mask every
  // stale tag, so resetting it would only add reset fan-out to a RAM-like array.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_LOOKUP && do_fill) begin
      tags_q[set_q][victim] <= tag_in_q;
    end
  end
endmodule

// File: tb/tb_way_select_ctrl.sv
// ---------------------------------------------------------------------------
// tb_way_select_ctrl: directed stimulus for way_select_ctrl (4 sets, 8 ways,
// 8-bit tags). Each request pushes its hand-computed response onto a queue;
// an independent monitor pops and compares on every response handshake.
// Inputs change 1 time unit after the rising edge, the monitor samples on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_way_select_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic reset;

  way_select_if #(.sets(4), .ways(8), .tag_bits(8)) bus ();

  way_select_ctrl #(.sets(4), .ways(8), .tag_bits(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             ev;
    logic [7:0]       evtag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: response seen with no request pending (way=%0d)", bus.resp_way);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".hit"},   32'(bus.resp_hit),         32'(mon_e.hit));
        check({mon_e.name, ".way"},   32'(bus.resp_way),         32'(mon_e.way));
        check({mon_e.name, ".ev"},    32'(bus.resp_evict_valid), 32'(mon_e.ev));
        check({mon_e.name, ".evtag"}, 32'(bus.resp_evict_tag),   32'(mon_e.evtag));
      end
    end
  end

  task automatic expect_resp(input string name, input logic hit, input logic [WAY_W-1:0] way,
                             input logic ev, input logic [7:0] evtag);
    exp_t e;
    e.name = name; e.hit = hit; e.way = way; e.ev = ev; e.evtag = evtag;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_req(input logic [1:0] op, input logic [1:0] set, input logic [7:0] tag);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = set;
    bus.req_tag   = tag;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s.timeout: pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input string name, input logic [1:0] op, input logic [1:0] set,
                      input logic [7:0] tag, input logic hit, input logic [WAY_W-1:0] way,
                      input logic ev, input logic [7:0] evtag);
    expect_resp(name, hit, way, ev, evtag);
    drive_req(op, set, tag);
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'd0;
    bus.req_set    = 2'd0;
    bus.req_tag    = 8'h00;
    bus.resp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready",  32'(bus.req_ready),        32'd0);
    check("rst.resp_valid", 32'(bus.resp_valid),       32'd0);
    check("rst.hit",        32'(bus.resp_hit),         32'd0);
    check("rst.way",        32'(bus.resp_way),         32'd0);
    check("rst.ev",         32'(bus.resp_evict_valid), 32'd0);
    check("rst.evtag",      32'(bus.resp_evict_tag),   32'd0);
    reset = 1'b0;
    #1;
    check("idle.req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // First miss with latency: accept at edge N, response up for the N+2
    // handshake, back in IDLE after it.
    expect_resp("s1_miss", 1'b0, 3'd0, 1'b0, 8'h00);
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_set = 2'd1; bus.req_tag = 8'h12;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("lat.after_n.valid",  32'(bus.resp_valid), 32'd0);
    check("lat.after_n.ready",  32'(bus.req_ready),  32'd0);
    @(posedge clk); #1;
    check("lat.after_n1.valid", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    check("lat.after_n2.valid", 32'(bus.resp_valid), 32'd0);
    check("lat.after_n2.ready", 32'(bus.req_ready),  32'd1);
    drain("s1_miss");

    send("s1_hit", 2'd0, 2'd1, 8'h12, 1'b1, 3'd0, 1'b0, 8'h00);

    // Fill set 2 in way order (invalid ways are taken lowest first).
    for (int i = 0; i < 8; i++) begin
      send($sformatf("fill%0d", i), 2'd0, 2'd2, 8'hA0 + 8'(i), 1'b0, 3'(i), 1'b0, 8'h00);
    end
    // After filling, every PLRU node is 0; the A0 hit sets nodes 0,1,3 to 1.
    send("hit_a0", 2'd0, 2'd2, 8'hA0, 1'b1, 3'd0, 1'b0, 8'h00);
    // Walk: n0=1 -> n2=0 -> n5=0 -> way 4. Touch sets n0=0, n2=1, n5=1.
    send("miss_b0", 2'd0, 2'd2, 8'hB0, 1'b0, 3'd4, 1'b1, 8'hA4);
    // Walk: n0=0 -> n1=1 -> n4=0 -> way 2; PROBE leaves it unchanged.
    send("probe_c0", 2'd1, 2'd2, 8'hC0, 1'b0, 3'd2, 1'b0, 8'h00);
    send("lookup_c0", 2'd0, 2'd2, 8'hC0, 1'b0, 3'd2, 1'b1, 8'hA2);
    send("inv_a3", 2'd2, 2'd2, 8'hA3, 1'b1, 3'd3, 1'b0, 8'h00);
    send("lookup_d0", 2'd0, 2'd2, 8'hD0, 1'b0, 3'd3, 1'b0, 8'h00);
    send("op3_d0", 2'd3, 2'd2, 8'hD0, 1'b1, 3'd3, 1'b0, 8'h00);
    send("inv_miss", 2'd2, 2'd2, 8'hEE, 1'b0, 3'd0, 1'b0, 8'h00);

    // Back-pressure: response held for 5 cycles while a stray request waits.
    bus.resp_ready = 1'b0;
    expect_resp("hold_probe", 1'b1, 3'd3, 1'b0, 8'h00);
    drive_req(2'd1, 2'd2, 8'hD0);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_set = 2'd3; bus.req_tag = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("hold.valid", 32'(bus.resp_valid),       32'd1);
      check("hold.ready", 32'(bus.req_ready),        32'd0);
      check("hold.hit",   32'(bus.resp_hit),         32'd1);
      check("hold.way",   32'(bus.resp_way),         32'd3);
      check("hold.ev",    32'(bus.resp_evict_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.release.valid", 32'(bus.resp_valid), 32'd0);
    check("hold.release.ready", 32'(bus.req_ready),  32'd1);
    drain("hold_probe");
    // The stray request must not have filled set 3.
    send("probe_s3", 2'd1, 2'd3, 8'h55, 1'b0, 3'd0, 1'b0, 8'h00);

    // Reset while a LOOKUP is in flight: no response, all lines invalid.
    drive_req(2'd0, 2'd1, 8'h77);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.req_ready",  32'(bus.req_ready),  32'd0);
    check("rst_mid.resp_valid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid.no_resp", 32'(bus.resp_valid), 32'd0);
    end
    send("post_rst_s1", 2'd0, 2'd1, 8'h12, 1'b0, 3'd0, 1'b0, 8'h00);
    send("post_rst_s2", 2'd1, 2'd2, 8'hD0, 1'b0, 3'd0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
